// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I main controller.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        JALR_PC,
        LUI,
        TRAP
    } state_t;

    // Major opcodes (Instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Controller-to-ALU-decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate format implied by the opcode; R-type and unknown opcodes fall back to I.
    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        sel = IMM_I;
        case (op)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_JAL:           sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/riscv_mc_alu_decoder.sv
// ALU control decode from the controller's operation class and the funct fields.
module riscv_mc_alu_decoder
    import riscv_mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 4
) (
    input  logic [1:0]           aluop,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    logic [3:0] code;

    // Map operation class and funct fields onto an ALU operation code
    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = ALUCTRL_W'(code);

endmodule

// File: rtl/riscv_mc_controller.sv
// Main FSM of the multicycle RV32I core with a req/ready memory handshake.
module riscv_mc_controller
    import riscv_mc_pkg::*;
#(
    parameter bit          MEM_WAIT     = 1'b1,
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int unsigned ALUCTRL_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 cout,
    input  logic                 overflow,
    input  logic                 sign,
    input  logic                 mem_ready,
    output logic [2:0]           imm_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic                 adr_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic                 mem_write,
    output logic                 mem_req,
    output logic                 illegal
);

    state_t     state, next_state;
    logic       ready;
    logic       branch_taken;
    logic [1:0] aluop;

    assign ready   = MEM_WAIT ? mem_ready : 1'b1;
    assign imm_src = imm_sel(op);

    riscv_mc_alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alu_control(alu_control)
    );

    // State register, asynchronously forced back to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Branch condition from the flags of the rs1 - rs2 subtraction
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            3'b100:  branch_taken = sign ^ overflow;
            3'b101:  branch_taken = ~(sign ^ overflow);
            3'b110:  branch_taken = ~cout;
            3'b111:  branch_taken = cout;
            default: branch_taken = 1'b0;
        endcase
    end

    // Next state and datapath controls; everything held at zero while reset is high
    always_comb begin
        next_state = state;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        aluop      = ALUOP_ADD;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    if (ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_LOAD, OP_STORE: next_state = MEMADR;
                        OP_RTYPE:          next_state = EXECR;
                        OP_ITYPE:          next_state = EXECI;
                        OP_BRANCH:         next_state = BRANCH;
                        OP_JAL:            next_state = JAL;
                        OP_JALR:           next_state = JALR;
                        OP_LUI:            next_state = LUI;
                        OP_AUIPC:          next_state = ALUWB;
                        default:           next_state = TRAP;
                    endcase
                end
                MEMADR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    next_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (ready) next_state = MEMWB;
                end
                MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                    next_state = FETCH;
                end
                MEMWRITE: begin
                    // mem_write stays up for the whole access so the memory sees a stable request
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (ready) next_state = FETCH;
                end
                EXECR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    aluop      = ALUOP_FUNCT;
                    next_state = ALUWB;
                end
                EXECI: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    aluop      = ALUOP_FUNCT;
                    next_state = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    next_state = FETCH;
                end
                BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    aluop      = ALUOP_SUB;
                    pc_write   = branch_taken;
                    next_state = FETCH;
                end
                JAL: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    pc_write   = 1'b1;
                    next_state = ALUWB;
                end
                JALR: begin
                    // rs1 is consumed here, so rd == rs1 cannot corrupt the target
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    next_state = JALR_PC;
                end
                JALR_PC: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    pc_write   = 1'b1;
                    next_state = ALUWB;
                end
                LUI: begin
                    alu_src_a  = SRCA_ZERO;
                    alu_src_b  = SRCB_IMM;
                    next_state = ALUWB;
                end
                TRAP: begin
                    illegal = 1'b1;
                    if (!ILLEGAL_HALT) next_state = FETCH;
                end
                default: next_state = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed cycle-by-cycle vectors for the multicycle main controller.
module tb_riscv_mc_controller;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] JR  = 7'b1100111;
    localparam logic [6:0] LU  = 7'b0110111;
    localparam logic [6:0] AU  = 7'b0010111;
    localparam logic [6:0] BAD = 7'h7F;

    // enables packed as {ir_write, pc_write, reg_write, mem_write, mem_req, illegal}
    localparam logic [5:0] E_NONE  = 6'b000000;
    localparam logic [5:0] E_FETCH = 6'b110010;
    localparam logic [5:0] E_STALL = 6'b000010;
    localparam logic [5:0] E_WB    = 6'b001000;
    localparam logic [5:0] E_PC    = 6'b010000;
    localparam logic [5:0] E_SW    = 6'b000110;
    localparam logic [5:0] E_ILL   = 6'b000001;

    typedef struct {
        string       nm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  fl;   // {zero, cout, overflow, sign}
        logic        rdy;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, cout, overflow, sign, mem_ready;

    logic       ir_w[3], pc_w[3], rg_w[3], mm_w[3], m_rq[3], ill[3], ad[3];
    logic [2:0] imm[3];
    logic [1:0] sa[3], sb[3], rs[3];
    logic [3:0] alu[3];
    logic [19:0] act[3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // instance 0: full features; 1: no halt on illegal; 2: memory wait ignored
    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_mc_controller #(
            .MEM_WAIT    (g != 2),
            .ILLEGAL_HALT(g != 1),
            .ALUCTRL_W   (4)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .op         (op),
            .funct3     (funct3),
            .funct7b5   (funct7b5),
            .zero       (zero),
            .cout       (cout),
            .overflow   (overflow),
            .sign       (sign),
            .mem_ready  (mem_ready),
            .imm_src    (imm[g]),
            .alu_src_a  (sa[g]),
            .alu_src_b  (sb[g]),
            .result_src (rs[g]),
            .adr_src    (ad[g]),
            .alu_control(alu[g]),
            .ir_write   (ir_w[g]),
            .pc_write   (pc_w[g]),
            .reg_write  (rg_w[g]),
            .mem_write  (mm_w[g]),
            .mem_req    (m_rq[g]),
            .illegal    (ill[g])
        );
        assign act[g] = {ir_w[g], pc_w[g], rg_w[g], mm_w[g], m_rq[g], ill[g],
                         imm[g], sa[g], sb[g], rs[g], ad[g], alu[g]};
    end

    function automatic logic [19:0] ex(logic [5:0] en, logic [2:0] im, logic [1:0] a,
                                       logic [1:0] b, logic [1:0] r, logic adr, logic [3:0] al);
        return {en, im, a, b, r, adr, al};
    endfunction

    function automatic void add(string nm, logic [6:0] o, logic [2:0] f3, logic f7,
                                logic [3:0] fl, logic rdy, logic [19:0] e);
        vec_t v;
        v.nm = nm; v.op = o; v.f3 = f3; v.f7 = f7; v.fl = fl; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic chk(string nm, logic [19:0] a, logic [19:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, a, e);
        end
    endtask

    task automatic drive(logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] fl, logic rdy);
        op = o; funct3 = f3; funct7b5 = f7;
        {zero, cout, overflow, sign} = fl;
        mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // R-type or I-type ALU instruction: FETCH, DECODE, EXEC, ALUWB
    function automatic void alu_instr(string nm, logic [6:0] o, logic [2:0] f3, logic f7, logic [3:0] al);
        logic [1:0] b;
        b = (o == R) ? 2'd0 : 2'd1;
        add({nm, ".fetch"},  o, f3, f7, 4'h0, 1'b1, ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add({nm, ".decode"}, o, f3, f7, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add({nm, ".exec"},   o, f3, f7, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd2, b,    2'd0, 1'b0, al));
        add({nm, ".aluwb"},  o, f3, f7, 4'h0, 1'b1, ex(E_WB,    3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
    endfunction

    // Branch: FETCH, DECODE, BRANCH with pc_write = taken
    function automatic void br_instr(string nm, logic [2:0] f3, logic [3:0] fl, logic taken);
        add({nm, ".fetch"},  BR, f3, 1'b0, fl, 1'b1, ex(E_FETCH, 3'd2, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add({nm, ".decode"}, BR, f3, 1'b0, fl, 1'b1, ex(E_NONE,  3'd2, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add({nm, ".branch"}, BR, f3, 1'b0, fl, 1'b1,
            ex(taken ? E_PC : E_NONE, 3'd2, 2'd2, 2'd0, 2'd0, 1'b0, 4'd1));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // add x3,x1,x2 and other ALU ops
        alu_instr("add",      R, 3'b000, 1'b0, 4'd0);
        alu_instr("sub",      R, 3'b000, 1'b1, 4'd1);
        alu_instr("sra",      R, 3'b101, 1'b1, 4'd9);
        alu_instr("srli",     I, 3'b101, 1'b0, 4'd8);
        alu_instr("addi_b30", I, 3'b000, 1'b1, 4'd0);
        alu_instr("andi",     I, 3'b111, 1'b0, 4'd2);
        // lw: 3 wait cycles in FETCH, 2 in MEMREAD, 10 cycles total
        for (int i = 0; i < 3; i++)
            add("lw.fetch_wait", LW, 3'b010, 1'b0, 4'h0, 1'b0, ex(E_STALL, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("lw.fetch",   LW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("lw.decode",  LW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("lw.memadr",  LW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0));
        for (int i = 0; i < 2; i++)
            add("lw.memread_wait", LW, 3'b010, 1'b0, 4'h0, 1'b0, ex(E_STALL, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        add("lw.memread", LW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_STALL, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        add("lw.memwb",   LW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_WB,    3'd0, 2'd0, 2'd0, 2'd1, 1'b0, 4'd0));
        // sw with one wait cycle in MEMWRITE
        add("sw.fetch",    SW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd1, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("sw.decode",   SW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd1, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("sw.memadr",   SW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd1, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0));
        add("sw.wr_wait",  SW, 3'b010, 1'b0, 4'h0, 1'b0, ex(E_SW,    3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        add("sw.wr",       SW, 3'b010, 1'b0, 4'h0, 1'b1, ex(E_SW,    3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        // branches
        br_instr("bltu_c0",  3'b110, 4'b0000, 1'b1);
        br_instr("bgeu_c0",  3'b111, 4'b0000, 1'b0);
        br_instr("beq_z1",   3'b000, 4'b1000, 1'b1);
        br_instr("bne_z1",   3'b001, 4'b1000, 1'b0);
        br_instr("blt_s1",   3'b100, 4'b0101, 1'b1);
        br_instr("f3_010",   3'b010, 4'b1111, 1'b0);
        // jal
        add("jal.fetch",  JL, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd3, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("jal.decode", JL, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd3, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("jal.jal",    JL, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_PC,    3'd3, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0));
        add("jal.aluwb",  JL, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_WB,    3'd3, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        // jalr x1,0(x1): 5 cycles
        add("jalr.fetch",  JR, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("jalr.decode", JR, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("jalr.jalr",   JR, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd0, 2'd2, 2'd1, 2'd0, 1'b0, 4'd0));
        add("jalr.pc",     JR, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_PC,    3'd0, 2'd1, 2'd2, 2'd0, 1'b0, 4'd0));
        add("jalr.aluwb",  JR, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_WB,    3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        // lui and auipc
        add("lui.fetch",  LU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd4, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("lui.decode", LU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd4, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("lui.lui",    LU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd4, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0));
        add("lui.aluwb",  LU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_WB,    3'd4, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        add("auipc.fetch",  AU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd4, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        add("auipc.decode", AU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_NONE,  3'd4, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        add("auipc.aluwb",  AU, 3'b000, 1'b0, 4'h0, 1'b1, ex(E_WB,    3'd4, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        add("after.fetch",  R,  3'b000, 1'b0, 4'h0, 1'b1, ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));

        // reset state: everything zero (R-type keeps imm_src at 000)
        reset = 1'b1;
        drive(R, 3'b000, 1'b0, 4'h0, 1'b1);
        #4;
        chk("reset.outputs", act[0], 20'h0);
        tick();
        chk("reset.held", act[0], 20'h0);
        reset = 1'b0;

        // table: instance 0 and instance 1 behave identically on legal code
        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].fl, tbl[i].rdy);
            #4;
            chk({tbl[i].nm, "/halt"},   act[0], tbl[i].exp);
            chk({tbl[i].nm, "/nohalt"}, act[1], tbl[i].exp);
            tick();
        end

        // illegal opcode: instance 0 parks in TRAP, instance 1 pulses once
        do_reset();
        drive(BAD, 3'b000, 1'b0, 4'h0, 1'b1);
        #4 chk("ill.fetch", act[0], ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        tick();
        #4 chk("ill.decode", act[0], ex(E_NONE, 3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));
        tick();
        #4 chk("ill.trap_halt",   act[0], ex(E_ILL, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        chk("ill.trap_nohalt", act[1], ex(E_ILL, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
        tick();
        #4 chk("ill.nohalt_fetch", act[1], ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            chk("ill.sticky", act[0], ex(E_ILL, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0));
            tick();
            #4;
        end
        reset = 1'b1;
        #1 chk("ill.reset_clears", act[0], 20'h0);
        tick();
        reset = 1'b0;
        drive(R, 3'b000, 1'b0, 4'h0, 1'b0);
        #4 chk("ill.after_reset", act[0], ex(E_STALL, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));

        // reset during a MEMWRITE wait
        do_reset();
        drive(SW, 3'b010, 1'b0, 4'h0, 1'b1);
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #4 chk("rst_sw.wait", act[0], ex(E_SW, 3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        tick();
        #4 chk("rst_sw.wait2", act[0], ex(E_SW, 3'd1, 2'd0, 2'd0, 2'd0, 1'b1, 4'd0));
        reset = 1'b1;
        #1 chk("rst_sw.drop", act[0], {6'b0, 3'd1, 11'b0});
        tick();
        reset = 1'b0;
        #4 chk("rst_sw.fetch_wait", act[0], ex(E_STALL, 3'd1, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        mem_ready = 1'b1;
        #1 chk("rst_sw.fetch", act[0], ex(E_FETCH, 3'd1, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));

        // MEM_WAIT=0: mem_ready ignored
        do_reset();
        drive(R, 3'b000, 1'b0, 4'h0, 1'b0);
        #4 chk("nowait.fetch", act[2], ex(E_FETCH, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        chk("wait.fetch_stall", act[0], ex(E_STALL, 3'd0, 2'd0, 2'd2, 2'd2, 1'b0, 4'd0));
        tick();
        #4 chk("nowait.decode", act[2], ex(E_NONE, 3'd0, 2'd1, 2'd1, 2'd0, 1'b0, 4'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
